// File: rtl/drive_pkg.sv
// Shared widths, limits and source encoding for the drive command path.
// The motor driver imports the same width constants.
package drive_pkg;

  localparam int SPEED_W   = 9;
  localparam int TURN_W    = 7;
  localparam int SPEED_MAX = 255;
  localparam int TURN_MAX  = 63;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_AUTO = 2'd1,
    SRC_MAN  = 2'd2
  } src_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AUTO = 2'd1,
    S_MAN  = 2'd2
  } state_e;

  // Only the most negative code lies outside the symmetric range.
  function automatic logic signed [SPEED_W-1:0] clamp_speed(input logic signed [SPEED_W-1:0] v);
    if (int'(v) < -SPEED_MAX) return SPEED_W'(-SPEED_MAX);
    return v;
  endfunction

  function automatic logic signed [TURN_W-1:0] clamp_turn(input logic signed [TURN_W-1:0] v);
    if (int'(v) < -TURN_MAX) return TURN_W'(-TURN_MAX);
    return v;
  endfunction

endpackage

// File: rtl/slew_limiter.sv
// Moves a signed output toward its target by at most STEP per tick, optionally
// parking at zero for DWELL_TICKS ticks when a step would change sign.
module slew_limiter #(
  parameter int W           = 9,
  parameter int STEP        = 8,
  parameter bit DWELL_EN    = 1'b0,
  parameter int DWELL_TICKS = 0
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                tick_in,
  input  logic signed [W-1:0] target_in,
  output logic signed [W-1:0] value_out
);

  localparam int CNT_W = $clog2(DWELL_TICKS + 2);
  localparam logic signed [W:0] L_STEP = (W+1)'(STEP);

  logic signed [W-1:0] r_value;
  logic [CNT_W-1:0]    r_dwell;
  logic                r_from_neg;

  logic signed [W:0] w_tgt;
  logic signed [W:0] w_cur;
  logic signed [W:0] w_diff;
  logic signed [W:0] w_next;
  logic              w_cross;
  logic              w_back;

  // One extra bit of headroom so the difference never wraps.
  always_comb begin
    w_tgt  = {target_in[W-1], target_in};
    w_cur  = {r_value[W-1], r_value};
    w_diff = w_tgt - w_cur;
    if (w_diff > L_STEP)       w_next = w_cur + L_STEP;
    else if (w_diff < -L_STEP) w_next = w_cur - L_STEP;
    else                       w_next = w_tgt;
    w_cross = (r_value != '0) && (w_next != '0) && (r_value[W-1] != w_next[W]);
    w_back  = r_from_neg ? (target_in[W-1] || (target_in == '0)) : !target_in[W-1];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_value    <= '0;
      r_dwell    <= '0;
      r_from_neg <= 1'b0;
    end else if (tick_in) begin
      if (DWELL_EN && (r_dwell != '0) && !w_back) begin
        r_dwell <= r_dwell - CNT_W'(1);
        r_value <= '0;
      end else if (DWELL_EN && w_cross) begin
        r_value    <= '0;
        r_dwell    <= CNT_W'(DWELL_TICKS);
        r_from_neg <= r_value[W-1];
      end else begin
        r_value <= w_next[W-1:0];
        r_dwell <= '0;
      end
    end
  end

  assign value_out = r_value;

endmodule

// File: rtl/drive_arbiter.sv
// Arbitrates manual/auto drive commands with a per-owner watchdog and slew-limited outputs.
// Define DRIVE_REVERSE_DWELL_EN to park speed at zero for REV_DWELL_TICKS ticks on reversal.
//
// state  | meaning
// S_IDLE | no owner, targets zero
// S_AUTO | tracker owns the targets, manual may preempt
// S_MAN  | operator owns the targets, auto strobes ignored
module drive_arbiter
  import drive_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 6500000,
  parameter int RAMP_DIV        = 65000,
  parameter int SPEED_STEP      = 8,
  parameter int TURN_STEP       = 4,
  parameter int REV_DWELL_TICKS = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      man_valid_in,
  input  logic signed [SPEED_W-1:0] man_speed_in,
  input  logic signed [TURN_W-1:0]  man_turn_in,
  input  logic                      auto_valid_in,
  input  logic signed [SPEED_W-1:0] auto_speed_in,
  input  logic signed [TURN_W-1:0]  auto_turn_in,
  input  logic                      stop_in,
  output logic signed [SPEED_W-1:0] speed_out,
  output logic signed [TURN_W-1:0]  turn_out,
  output logic [1:0]                src_out,
  output logic                      timeout_out
);

  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DIV_W = $clog2(RAMP_DIV + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
`ifdef DRIVE_REVERSE_DWELL_EN
  localparam bit DWELL_EN = 1'b1;
`else
  localparam bit DWELL_EN = 1'b0;
`endif

  state_e                    r_state;
  src_e                      r_src;
  logic signed [SPEED_W-1:0] r_tgt_speed;
  logic signed [TURN_W-1:0]  r_tgt_turn;
  logic [WD_W-1:0]           r_wd;
  logic                      r_timeout;
  logic [DIV_W-1:0]          r_div;
  logic                      w_tick;

  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in || w_tick) r_div <= '0;
    else                  r_div <= r_div + DIV_W'(1);
  end

  // Priority: stop, then manual strobe, then auto strobe (unless manual owns), then watchdog.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_src       <= SRC_NONE;
      r_tgt_speed <= '0;
      r_tgt_turn  <= '0;
      r_wd        <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (stop_in) begin
        r_state     <= S_IDLE;
        r_src       <= SRC_NONE;
        r_tgt_speed <= '0;
        r_tgt_turn  <= '0;
        r_wd        <= '0;
      end else if (man_valid_in) begin
        r_state     <= S_MAN;
        r_src       <= SRC_MAN;
        r_tgt_speed <= clamp_speed(man_speed_in);
        r_tgt_turn  <= clamp_turn(man_turn_in);
        r_wd        <= '0;
      end else if (auto_valid_in && (r_state != S_MAN)) begin
        r_state     <= S_AUTO;
        r_src       <= SRC_AUTO;
        r_tgt_speed <= clamp_speed(auto_speed_in);
        r_tgt_turn  <= clamp_turn(auto_turn_in);
        r_wd        <= '0;
      end else if (r_state != S_IDLE) begin
        if (r_wd == WD_LAST) begin
          r_state     <= S_IDLE;
          r_src       <= SRC_NONE;
          r_tgt_speed <= '0;
          r_tgt_turn  <= '0;
          r_wd        <= '0;
          r_timeout   <= 1'b1;
        end else begin
          r_wd <= r_wd + WD_W'(1);
        end
      end
    end
  end

  slew_limiter #(
    .W(SPEED_W), .STEP(SPEED_STEP), .DWELL_EN(DWELL_EN), .DWELL_TICKS(REV_DWELL_TICKS)
  ) u_speed (
    .clk_in(clk_in), .rst_in(rst_in), .tick_in(w_tick),
    .target_in(r_tgt_speed), .value_out(speed_out)
  );

  slew_limiter #(
    .W(TURN_W), .STEP(TURN_STEP), .DWELL_EN(1'b0), .DWELL_TICKS(0)
  ) u_turn (
    .clk_in(clk_in), .rst_in(rst_in), .tick_in(w_tick),
    .target_in(r_tgt_turn), .value_out(turn_out)
  );

  assign src_out     = r_src;
  assign timeout_out = r_timeout;

endmodule
